// File: rtl/place_eval_if.sv
// Memory-side bus of place_eval: edge ROM reads (index -> endpoint IDs) and
// position RAM reads (node ID -> signed x/y), one-cycle read latency on both.
interface place_eval_if #(
    parameter int unsigned EDGE_AW = 9,
    parameter int unsigned POS_AW  = 7
) ();
    logic                      edge_re;
    logic [EDGE_AW-1:0]        edge_addr;
    logic [31:0]               edge_a;
    logic [31:0]               edge_b;
    logic                      pos_re;
    logic [POS_AW-1:0]         pos_addr;
    logic signed [31:0]        pos_x;
    logic signed [31:0]        pos_y;

    modport master (
        output edge_re, edge_addr, pos_re, pos_addr,
        input  edge_a, edge_b, pos_x, pos_y
    );

    modport slave (
        input  edge_re, edge_addr, pos_re, pos_addr,
        output edge_a, edge_b, pos_x, pos_y
    );
endinterface

// File: rtl/place_eval.sv
// Placement wirelength evaluator: walks N_EDGE edges, fetches both endpoint
// positions and accumulates Manhattan and 1-hop wirelength. Optional
// unplaced-node detection (err output) with PLACE_EVAL_UNPLACED_CHK_EN.
module place_eval #(
    parameter int unsigned N_EDGE  = 71,
    parameter int unsigned EDGE_AW = 9,
    parameter int unsigned POS_AW  = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    place_eval_if.master       mem,
    output logic signed [31:0] sum,
    output logic signed [31:0] sum_1hop,
    output logic        [31:0] cycles
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned DW = 32;

    typedef enum logic [3:0] {
        IDLE, REQ_E, WAIT_E, REQ_A, WAIT_A, REQ_B, WAIT_B, ACC, FIN
    } state_t;

    state_t              state, state_nxt;
    logic [EDGE_AW-1:0]  idx, idx_nxt;
    logic [POS_AW-1:0]   node_b, node_b_nxt;
    logic [DW-1:0]       ax, ay, bx, by;
    logic [DW-1:0]       ax_nxt, ay_nxt, bx_nxt, by_nxt;
    logic                edge_re, edge_re_nxt;
    logic [EDGE_AW-1:0]  edge_addr, edge_addr_nxt;
    logic                pos_re, pos_re_nxt;
    logic [POS_AW-1:0]   pos_addr, pos_addr_nxt;
    logic                busy_nxt, done_nxt;
    logic [DW-1:0]       sum_nxt, sum_1hop_nxt, cycles_nxt;
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
    logic                err_nxt;
    logic                unplaced_c;
`endif

    // Edge cost terms from the latched endpoint coordinates
    logic [DW-1:0] diff_x_c, diff_y_c, dx_c, dy_c, step_c, step_1hop_c;
    logic          last_c;

    assign diff_x_c    = ax - bx;
    assign diff_y_c    = ay - by;
    assign dx_c        = diff_x_c[DW-1] ? (DW'(0) - diff_x_c) : diff_x_c;
    assign dy_c        = diff_y_c[DW-1] ? (DW'(0) - diff_y_c) : diff_y_c;
    assign step_c      = dx_c + dy_c - DW'(1);
    assign step_1hop_c = (dx_c >> 1) + DW'(dx_c[0]) + (dy_c >> 1) + DW'(dy_c[0]) - DW'(1);
    assign last_c      = ((DW'(idx) + DW'(1)) == N_EDGE);
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
    assign unplaced_c  = (ax == '1) || (ay == '1) || (bx == '1) || (by == '1);
`endif

    // Node ID bits above the position-memory address range are not used
    logic unused_id_bits;
    assign unused_id_bits = ^{mem.edge_a[DW-1:POS_AW], mem.edge_b[DW-1:POS_AW]};

    assign mem.edge_re   = edge_re;
    assign mem.edge_addr = edge_addr;
    assign mem.pos_re    = pos_re;
    assign mem.pos_addr  = pos_addr;

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        node_b_nxt    = node_b;
        ax_nxt        = ax;
        ay_nxt        = ay;
        bx_nxt        = bx;
        by_nxt        = by;
        edge_re_nxt   = 1'b0;
        edge_addr_nxt = edge_addr;
        pos_re_nxt    = 1'b0;
        pos_addr_nxt  = pos_addr;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        sum_nxt       = sum;
        sum_1hop_nxt  = sum_1hop;
        cycles_nxt    = (busy && (cycles != '1)) ? cycles + DW'(1) : cycles;
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
        err_nxt       = err;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    sum_nxt      = '0;
                    sum_1hop_nxt = '0;
                    // The accepting cycle itself is the first counted cycle
                    cycles_nxt   = DW'(1);
                    idx_nxt      = '0;
                    busy_nxt     = 1'b1;
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
                    err_nxt      = 1'b0;
`endif
                    if (N_EDGE == 0) begin
                        state_nxt = FIN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt     = REQ_E;
                        edge_re_nxt   = 1'b1;
                        edge_addr_nxt = '0;
                    end
                end
            end
            REQ_E: state_nxt = WAIT_E;
            WAIT_E: begin
                node_b_nxt   = mem.edge_b[POS_AW-1:0];
                state_nxt    = REQ_A;
                pos_re_nxt   = 1'b1;
                pos_addr_nxt = mem.edge_a[POS_AW-1:0];
            end
            REQ_A: state_nxt = WAIT_A;
            WAIT_A: begin
                ax_nxt       = mem.pos_x;
                ay_nxt       = mem.pos_y;
                state_nxt    = REQ_B;
                pos_re_nxt   = 1'b1;
                pos_addr_nxt = node_b;
            end
            REQ_B: state_nxt = WAIT_B;
            WAIT_B: begin
                bx_nxt    = mem.pos_x;
                by_nxt    = mem.pos_y;
                state_nxt = ACC;
            end
            ACC: begin
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
                if (unplaced_c) begin
                    err_nxt = 1'b1;
                end else begin
                    sum_nxt      = sum + step_c;
                    sum_1hop_nxt = sum_1hop + step_1hop_c;
                end
`else
                sum_nxt      = sum + step_c;
                sum_1hop_nxt = sum_1hop + step_1hop_c;
`endif
                idx_nxt = idx + EDGE_AW'(1);
                if (last_c) begin
                    state_nxt = FIN;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt     = REQ_E;
                    edge_re_nxt   = 1'b1;
                    edge_addr_nxt = idx + EDGE_AW'(1);
                end
            end
            FIN: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            node_b    <= '0;
            ax        <= '0;
            ay        <= '0;
            bx        <= '0;
            by        <= '0;
            edge_re   <= 1'b0;
            edge_addr <= '0;
            pos_re    <= 1'b0;
            pos_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            sum_1hop  <= '0;
            cycles    <= '0;
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            node_b    <= node_b_nxt;
            ax        <= ax_nxt;
            ay        <= ay_nxt;
            bx        <= bx_nxt;
            by        <= by_nxt;
            edge_re   <= edge_re_nxt;
            edge_addr <= edge_addr_nxt;
            pos_re    <= pos_re_nxt;
            pos_addr  <= pos_addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            sum       <= sum_nxt;
            sum_1hop  <= sum_1hop_nxt;
            cycles    <= cycles_nxt;
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
            err       <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_place_eval.sv
// Bench for place_eval: one single-edge and one two-edge instance sharing
// behavioural edge/position memories; results compared to a wirelength model.
module tb_place_eval;

    localparam int unsigned EDGE_AW = 9;
    localparam int unsigned POS_AW  = 7;

    logic clk;
    logic reset;
    logic start1, start2;
    logic busy1, busy2, done1, done2;
    logic signed [31:0] sum1, sum2, hop1, hop2;
    logic [31:0] cyc1, cyc2;
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
    logic err1, err2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;

    logic [31:0] ea_mem [512];
    logic [31:0] eb_mem [512];
    int          px_mem [128];
    int          py_mem [128];

    place_eval_if #(.EDGE_AW(EDGE_AW), .POS_AW(POS_AW)) m1 ();
    place_eval_if #(.EDGE_AW(EDGE_AW), .POS_AW(POS_AW)) m2 ();

    place_eval #(.N_EDGE(1), .EDGE_AW(EDGE_AW), .POS_AW(POS_AW)) u_one (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .mem(m1), .sum(sum1), .sum_1hop(hop1), .cycles(cyc1)
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
        , .err(err1)
`endif
    );

    place_eval #(.N_EDGE(2), .EDGE_AW(EDGE_AW), .POS_AW(POS_AW)) u_two (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .mem(m2), .sum(sum2), .sum_1hop(hop2), .cycles(cyc2)
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
        , .err(err2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories with one-cycle read latency
    always @(posedge clk) begin
        if (m1.edge_re) begin m1.edge_a <= ea_mem[m1.edge_addr]; m1.edge_b <= eb_mem[m1.edge_addr]; end
        if (m1.pos_re)  begin m1.pos_x  <= px_mem[m1.pos_addr];  m1.pos_y  <= py_mem[m1.pos_addr];  end
        if (m2.edge_re) begin m2.edge_a <= ea_mem[m2.edge_addr]; m2.edge_b <= eb_mem[m2.edge_addr]; end
        if (m2.pos_re)  begin m2.pos_x  <= px_mem[m2.pos_addr];  m2.pos_y  <= py_mem[m2.pos_addr];  end
    end

    // Read strobes: never together, never two cycles in a row
    logic e1p = 1'b0, p1p = 1'b0, e2p = 1'b0, p2p = 1'b0;
    always @(negedge clk) begin
        if (m1.edge_re && m1.pos_re) viol++;
        if (m2.edge_re && m2.pos_re) viol++;
        if ((m1.edge_re && e1p) || (m1.pos_re && p1p)) viol++;
        if ((m2.edge_re && e2p) || (m2.pos_re && p2p)) viol++;
        e1p = m1.edge_re; p1p = m1.pos_re; e2p = m2.edge_re; p2p = m2.pos_re;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start2 = v; else start1 = v;
    endtask

    function automatic logic get_done(input int sel);
        return (sel != 0) ? done2 : done1;
    endfunction

    // Cycle 1 is the cycle start is high; returns the first cycle done is seen
    task automatic run(input int sel, input int max_cyc, input int extra_start, input int rst_at,
                       output int done_cyc, output int n_done);
        int c;
        done_cyc = 0;
        n_done   = 0;
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        c = 2;
        while (c <= max_cyc) begin
            if (get_done(sel)) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == rst_at) begin
                reset = 1'b0;
                return;
            end
            set_start(sel, c == extra_start);
            @(negedge clk);
            c++;
        end
    endtask

    // Reference: total wirelength over the first n edges, from the definitions
    function automatic void model(input int n, output logic [31:0] s, output logic [31:0] s1,
                                  output logic e);
        longint acc  = 0;
        longint acc1 = 0;
        e = 1'b0;
        for (int i = 0; i < n; i++) begin
            int a, b;
            longint dx, dy;
            a = int'(ea_mem[i] % 128);
            b = int'(eb_mem[i] % 128);
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
            if (px_mem[a] == -1 || py_mem[a] == -1 || px_mem[b] == -1 || py_mem[b] == -1) begin
                e = 1'b1;
                continue;
            end
`endif
            dx = longint'(px_mem[a]) - longint'(px_mem[b]);
            dy = longint'(py_mem[a]) - longint'(py_mem[b]);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            acc  += dx + dy - 1;
            acc1 += (dx + 1) / 2 + (dy + 1) / 2 - 1;
        end
        s  = acc[31:0];
        s1 = acc1[31:0];
    endfunction

    task automatic set_edge(input int i, input int a, input int b);
        ea_mem[i] = 32'(a);
        eb_mem[i] = 32'(b);
    endtask

    task automatic set_pos(input int n, input int x, input int y);
        px_mem[n] = x;
        py_mem[n] = y;
    endtask

    initial begin
        int dc, nd;
        logic [31:0] es, es1;
        logic ee;

        reset  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 512; i++) begin ea_mem[i] = '0; eb_mem[i] = '0; end
        for (int i = 0; i < 128; i++) set_pos(i, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_sum", sum1, 0);
        check("rst_hop", hop1, 0);
        check("rst_cycles", cyc1, 0);
        check("rst_strobes", 32'({m1.edge_re, m1.pos_re}), 0);
        check("rst_addr", 32'({m1.edge_addr, m1.pos_addr}), 0);
        reset = 1'b1;

        // Single edge
        set_edge(0, 0, 1); set_pos(0, 0, 0); set_pos(1, 3, 2);
        run(0, 15, 0, 0, dc, nd);
        check("single_done_cyc", 32'(dc), 9);
        check("single_done_cnt", 32'(nd), 1);
        check("single_sum", sum1, 4);
        check("single_hop", hop1, 2);
        check("single_cycles", cyc1, 9);
        check("single_busy_after", 32'(busy1), 0);

        // Coincident endpoints
        set_edge(0, 2, 2); set_pos(2, 5, 5);
        run(0, 15, 0, 0, dc, nd);
        check("coinc_sum", sum1, 32'hFFFF_FFFF);
        check("coinc_hop", hop1, 32'hFFFF_FFFF);

        // Negative differences
        set_edge(0, 4, 5); set_pos(4, 7, 1); set_pos(5, 0, 6);
        run(0, 15, 0, 0, dc, nd);
        check("negdiff_sum", sum1, 11);
        check("negdiff_hop", hop1, 6);
        check("negdiff_cycles", cyc1, 9);

        // Reset in the middle of a run
        set_edge(0, 0, 1);
        run(0, 15, 0, 5, dc, nd);
        check("midrst_no_done", 32'(nd), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_outs", 32'({busy1, done1, m1.edge_re, m1.pos_re}), 0);
            check("midrst_cycles", cyc1, 0);
        end
        reset = 1'b1;
        run(0, 15, 0, 0, dc, nd);
        check("fresh_done_cyc", 32'(dc), 9);
        check("fresh_sum", sum1, 4);
        check("fresh_hop", hop1, 2);
        check("fresh_cycles", cyc1, 9);

        // Start while busy is ignored
        set_edge(0, 0, 1); set_edge(1, 4, 5);
        model(2, es, es1, ee);
        run(1, 30, 3, 0, dc, nd);
        check("busy_start_done_cyc", 32'(dc), 16);
        check("busy_start_done_cnt", 32'(nd), 1);
        check("busy_start_sum", sum2, es);
        check("busy_start_hop", hop2, es1);
        check("busy_start_cycles", cyc2, 16);

        // Randomized two-edge runs
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 2; i++) set_edge(i, int'($urandom_range(127)), int'($urandom_range(127)));
            for (int i = 0; i < 128; i++)
                set_pos(i, int'($urandom_range(20000)) - 10000, int'($urandom_range(20000)) - 10000);
            if (r == 5) set_pos(int'(ea_mem[0]), -1, 3);
            model(2, es, es1, ee);
            run(1, 24, 0, 0, dc, nd);
            check("rand_done_cyc", 32'(dc), 16);
            check("rand_sum", sum2, es);
            check("rand_hop", hop2, es1);
            check("rand_cycles", cyc2, 16);
`ifdef PLACE_EVAL_UNPLACED_CHK_EN
            check("rand_err", 32'(err2), 32'(ee));
`endif
        end

`ifdef PLACE_EVAL_UNPLACED_CHK_EN
        // Unplaced endpoint skips its edge and flags err
        set_edge(0, 0, 1); set_edge(1, 0, 2);
        set_pos(0, 0, 0); set_pos(1, -1, -1); set_pos(2, 1, 0);
        run(1, 24, 0, 0, dc, nd);
        check("unplaced_err", 32'(err2), 1);
        check("unplaced_sum", sum2, 0);
        check("unplaced_hop", hop2, 0);
        set_pos(1, 3, 2);
        run(1, 24, 0, 0, dc, nd);
        check("unplaced_err_clear", 32'(err2), 0);
`endif

        check("strobe_rules", 32'(viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
